multi_clk_div: RTL and testbench

- Parametrised, multi-channel successor to the fixed single-output frequency divider.
- Each channel divides the system clock by a runtime-programmable terminal count.
- Each channel runs in either toggle mode (square clock, ~50% duty) or pulse mode (one-cycle tick strobe).
- Sits beside the system clock and feeds display-scan, debounce, buzzer and timebase logic, replacing the per-rate divider copies.

---
 rtl/clk_div_pkg.sv | 19 +
 rtl/clk_div_ch.sv | 126 ++++++++++++
 rtl/multi_clk_div.sv | 54 +++++
 tb/tb_multi_clk_div.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider: mode encodings,
// terminal counts for the common rates, and a select-width helper.
package clk_div_pkg;

    // Channel output modes
    localparam logic MODE_TOGGLE = 1'b0;   // square clock on clk_div
    localparam logic MODE_PULSE  = 1'b1;   // one-cycle strobe on tick

    // Terminal counts for the common rates from a 50 MHz system clock
    localparam int TC_10KHZ = 2500;
    localparam int TC_1KHZ  = 25000;
    localparam int TC_1HZ   = 25000000;

    // Width of a channel-select field; never narrower than one bit
    function automatic int ch_sel_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage : clk_div_pkg

// File: rtl/clk_div_ch.sv
// One divider channel: free-running counter with a programmable terminal
// count, shadow/active configuration pair for glitch-free retuning, and the
// registered toggle/pulse output flops.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int DEFAULT_TC   = TC_10KHZ,
    parameter int DEFAULT_MODE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_sync_clr,
    input  logic             i_we,
    input  logic [CNT_W-1:0] i_tc,
    input  logic             i_mode,
    output logic             o_clk_div,
    output logic             o_tick,
    output logic             o_pend
);

    localparam logic [CNT_W-1:0] DEF_TC   = CNT_W'(DEFAULT_TC);
    localparam logic             DEF_MODE = (DEFAULT_MODE != 0);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_act_tc;
    logic             r_act_mode;
    logic [CNT_W-1:0] r_shd_tc;
    logic             r_shd_mode;
    logic             r_pend;
    logic             r_clk_div;
    logic             r_tick;

    logic             w_wrap;
    logic             w_mode_change;

    // The counter never exceeds the active TC: a new TC only becomes active
    // while the count is being forced back to zero.
    assign w_wrap        = (r_cnt == r_act_tc);
    // A pending shadow with a different mode restarts both outputs from 0
    assign w_mode_change = r_pend && (r_shd_mode != r_act_mode);

    // Shadow/active configuration and pending flag
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: the configuration registers are a handful of control flops,
        // not a RAM, so they take the reset like every other state bit.
        if (reset) begin
            r_act_tc   <= DEF_TC;
            r_act_mode <= DEF_MODE;
            r_shd_tc   <= DEF_TC;
            r_shd_mode <= DEF_MODE;
            r_pend     <= 1'b0;
        end else if (i_sync_clr) begin
            // Apply what was already pending; a write in this same cycle
            // lands in the shadow and waits for the next apply point.
            if (r_pend) begin
                r_act_tc   <= r_shd_tc;
                r_act_mode <= r_shd_mode;
            end
            // NOTE: non-blocking assignments make the later write below win
            // over the clear above, while both still see the old r_pend.
            r_pend <= 1'b0;
            if (i_we) begin
                r_shd_tc   <= i_tc;
                r_shd_mode <= i_mode;
                r_pend     <= 1'b1;
            end
        end else if (!i_en) begin
            // Idle channel: nothing to glitch, so configuration goes live now
            if (i_we) begin
                r_act_tc   <= i_tc;
                r_act_mode <= i_mode;
                r_shd_tc   <= i_tc;
                r_shd_mode <= i_mode;
            end else if (r_pend) begin
                r_act_tc   <= r_shd_tc;
                r_act_mode <= r_shd_mode;
            end
            r_pend <= 1'b0;
        end else begin
            // Running channel: retune only at the wrap edge
            if (w_wrap && r_pend) begin
                r_act_tc   <= r_shd_tc;
                r_act_mode <= r_shd_mode;
                r_pend     <= 1'b0;
            end
            if (i_we) begin
                r_shd_tc   <= i_tc;
                r_shd_mode <= i_mode;
                r_pend     <= 1'b1;
            end
        end
    end

    // Counter and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_clk_div <= 1'b0;
            r_tick    <= 1'b0;
        end else if (i_sync_clr || !i_en) begin
            r_cnt     <= '0;
            r_clk_div <= 1'b0;
            r_tick    <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            if (w_mode_change) begin
                r_clk_div <= 1'b0;
                r_tick    <= 1'b0;
            end else if (r_act_mode == MODE_PULSE) begin
                r_tick <= 1'b1;
            end else begin
                r_clk_div <= ~r_clk_div;
            end
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_tick <= 1'b0;
        end
    end

    assign o_clk_div = r_clk_div;
    assign o_tick    = r_tick;
    assign o_pend    = r_pend;

endmodule : clk_div_ch

// File: rtl/multi_clk_div.sv
// Multi-channel programmable clock divider. Decodes configuration writes to
// one channel and fans the global phase-align strobe out to all channels.
module multi_clk_div
    import clk_div_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int N_CH         = 4,
    parameter int DEFAULT_TC   = TC_10KHZ,
    parameter int DEFAULT_MODE = 0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_CH-1:0]                ch_en,
    input  logic                           sync_clr,
    input  logic                           cfg_we,
    input  logic [ch_sel_width(N_CH)-1:0]  cfg_ch,
    input  logic [CNT_W-1:0]               cfg_tc,
    input  logic                           cfg_mode,
    output logic [N_CH-1:0]                clk_div,
    output logic [N_CH-1:0]                tick,
    output logic [N_CH-1:0]                cfg_pend
);

    logic [N_CH-1:0] w_ch_we;

    // One-hot write decode; addresses beyond the last channel are dropped
    always_comb begin
        // NOTE: default assignment first keeps this block free of latches.
        w_ch_we = '0;
        if (cfg_we && (32'(cfg_ch) < N_CH)) begin
            w_ch_we[cfg_ch] = 1'b1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clk_div_ch #(
            .CNT_W        (CNT_W),
            .DEFAULT_TC   (DEFAULT_TC),
            .DEFAULT_MODE (DEFAULT_MODE)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .i_en       (ch_en[g]),
            .i_sync_clr (sync_clr),
            .i_we       (w_ch_we[g]),
            .i_tc       (cfg_tc),
            .i_mode     (cfg_mode),
            .o_clk_div  (clk_div[g]),
            .o_tick     (tick[g]),
            .o_pend     (cfg_pend[g])
        );
    end

endmodule : multi_clk_div

// File: tb/tb_multi_clk_div.sv
// Self-checking bench for multi_clk_div: directed rate/retune/sync/reset
// sequences, a table of per-configuration output shapes, and a randomized
// run against a cycle-level behavioural model.
module tb_multi_clk_div;

    localparam int CNT_W = 32;
    localparam int N_CH  = 3;    // odd count so cfg_ch = 3 is an unused address
    localparam int CH_W  = 2;

    logic              clock;
    logic              reset;
    logic [N_CH-1:0]   ch_en;
    logic              sync_clr;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_tc;
    logic              cfg_mode;
    logic [N_CH-1:0]   clk_div;
    logic [N_CH-1:0]   tick;
    logic [N_CH-1:0]   cfg_pend;

    int n_checks = 0;
    int n_fail   = 0;

    multi_clk_div #(
        .CNT_W        (CNT_W),
        .N_CH         (N_CH),
        .DEFAULT_TC   (2500),
        .DEFAULT_MODE (0)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ch_en    (ch_en),
        .sync_clr (sync_clr),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_tc   (cfg_tc),
        .cfg_mode (cfg_mode),
        .clk_div  (clk_div),
        .tick     (tick),
        .cfg_pend (cfg_pend)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input int ch, input int tc, input logic mode);
        cfg_we   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_tc   = CNT_W'(tc);
        cfg_mode = mode;
    endtask

    // Table of configurations: output shape over 24 cycles after enable
    typedef struct {
        int   tc;
        logic mode;
        int   exp_first;   // first cycle after enable where the output is 1
        int   exp_count;   // cycles with the output at 1 in the window
    } vec_t;

    // Behavioural model of one channel, stepped once per clock edge
    typedef struct {
        int unsigned cnt;
        int unsigned tc;
        bit          mode;
        int unsigned sh_tc;
        bit          sh_mode;
        bit          pend;
        bit          clk;
        bit          tick;
    } ch_model_t;

    ch_model_t m [N_CH];

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m[i] = '{cnt: 0, tc: 2500, mode: 0, sh_tc: 2500, sh_mode: 0,
                     pend: 0, clk: 0, tick: 0};
        end
    endtask

    // Advance the model over one edge given the inputs held across that edge
    task automatic model_step(input logic [N_CH-1:0] en, input logic sync,
                              input logic we, input logic [CH_W-1:0] ch,
                              input int unsigned tc, input logic mode);
        for (int i = 0; i < N_CH; i++) begin
            bit wr;
            wr = we && (int'(ch) == i);
            if (sync) begin
                if (m[i].pend) begin
                    m[i].tc   = m[i].sh_tc;
                    m[i].mode = m[i].sh_mode;
                end
                m[i].pend = 0;
                m[i].cnt = 0; m[i].clk = 0; m[i].tick = 0;
                if (wr) begin
                    m[i].sh_tc = tc; m[i].sh_mode = mode; m[i].pend = 1;
                end
            end else if (!en[i]) begin
                m[i].cnt = 0; m[i].clk = 0; m[i].tick = 0;
                if (wr) begin
                    m[i].tc = tc; m[i].mode = mode;
                    m[i].sh_tc = tc; m[i].sh_mode = mode;
                end else if (m[i].pend) begin
                    m[i].tc = m[i].sh_tc; m[i].mode = m[i].sh_mode;
                end
                m[i].pend = 0;
            end else begin
                if (m[i].cnt == m[i].tc) begin
                    bit old_mode;
                    old_mode = m[i].mode;
                    if (m[i].pend) begin
                        m[i].tc = m[i].sh_tc; m[i].mode = m[i].sh_mode; m[i].pend = 0;
                    end
                    m[i].cnt = 0;
                    if (m[i].mode != old_mode) begin
                        m[i].clk = 0; m[i].tick = 0;
                    end else if (m[i].mode) begin
                        m[i].tick = 1;
                    end else begin
                        m[i].clk = !m[i].clk;
                    end
                end else begin
                    m[i].cnt++;
                    m[i].tick = 0;
                end
                if (wr) begin
                    m[i].sh_tc = tc; m[i].sh_mode = mode; m[i].pend = 1;
                end
            end
        end
    endtask

    initial begin
        vec_t        vecs [6];
        int          first, second, cnt_main, cnt_other;
        bit          prev;
        logic [15:0] cap_a, cap_b, cap_c;
        logic [N_CH-1:0] exp_clk, exp_tick, exp_pend;
        logic [N_CH-1:0] r_en;
        logic        r_sync, r_we, r_mode;
        logic [CH_W-1:0] r_ch;
        int unsigned r_tc;

        vecs[0] = '{tc: 3, mode: 1'b1, exp_first: 4, exp_count: 6};
        vecs[1] = '{tc: 0, mode: 1'b0, exp_first: 1, exp_count: 12};
        vecs[2] = '{tc: 5, mode: 1'b0, exp_first: 6, exp_count: 12};
        vecs[3] = '{tc: 1, mode: 1'b1, exp_first: 2, exp_count: 12};
        vecs[4] = '{tc: 7, mode: 1'b0, exp_first: 8, exp_count: 9};
        vecs[5] = '{tc: 0, mode: 1'b1, exp_first: 1, exp_count: 24};

        reset = 1'b1; ch_en = '0; sync_clr = 1'b0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_tc = '0; cfg_mode = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs", {clk_div, tick, cfg_pend}, '0);

        // Default channel: TC = 2500 toggle, first rise 2501 cycles after enable
        reset = 1'b0;
        ch_en = 3'b001;
        first = 0; second = 0; cnt_other = 0; prev = 1'b0;
        for (int k = 1; k <= 7600; k++) begin
            @(negedge clock);
            if (clk_div[0] && !prev) begin
                if (first == 0) first = k;
                else if (second == 0) second = k;
            end
            prev = clk_div[0];
            cnt_other += int'(tick[0]);
        end
        check("default_first_rise", first, 2501);
        check("default_period", second - first, 5002);
        check("default_tick_quiet", cnt_other, 0);

        // Reset mid-period with a pending shadow: outputs drop asynchronously
        cfg_write(0, 10, 1'b0);
        @(negedge clock);
        cfg_we = 1'b0;
        check("prereset_pend", cfg_pend[0], 1'b1);
        check("prereset_clk", clk_div[0], 1'b1);
        #2 reset = 1'b1;
        #1 check("async_reset_outputs", {clk_div, tick, cfg_pend}, '0);
        @(negedge clock);
        reset = 1'b0;
        first = 0;
        for (int k = 1; k <= 2600; k++) begin
            @(negedge clock);
            if (clk_div[0] && first == 0) first = k;
        end
        check("post_reset_first_rise", first, 2501);
        check("post_reset_pend", cfg_pend[0], 1'b0);

        // Table: configure channel 1 while idle, then watch 24 cycles
        ch_en = '0;
        for (int v = 0; v < 6; v++) begin
            @(negedge clock);
            ch_en[1] = 1'b0;
            cfg_write(1, vecs[v].tc, vecs[v].mode);
            @(negedge clock);
            cfg_we = 1'b0;
            check($sformatf("tbl%0d_pend_idle", v), cfg_pend[1], 1'b0);
            check($sformatf("tbl%0d_idle_outs", v), {clk_div[1], tick[1]}, 2'b00);
            ch_en[1] = 1'b1;
            first = 0; cnt_main = 0; cnt_other = 0;
            for (int k = 1; k <= 24; k++) begin
                logic o_main, o_other;
                @(negedge clock);
                o_main  = vecs[v].mode ? tick[1] : clk_div[1];
                o_other = vecs[v].mode ? clk_div[1] : tick[1];
                if (o_main && first == 0) first = k;
                cnt_main  += int'(o_main);
                cnt_other += int'(o_other);
            end
            check($sformatf("tbl%0d_first", v), first, vecs[v].exp_first);
            check($sformatf("tbl%0d_count", v), cnt_main, vecs[v].exp_count);
            check($sformatf("tbl%0d_other_quiet", v), cnt_other, 0);
        end

        // Drop enable with TC = 0 pulse: tick falls on the next edge
        ch_en[1] = 1'b0;
        @(negedge clock);
        check("drop_en_outs", {clk_div[1], tick[1]}, 2'b00);

        // Retune mid-count on channel 2: TC 9 -> 1 written at count 4
        @(negedge clock);
        ch_en = '0;
        cfg_write(2, 9, 1'b0);
        @(negedge clock);
        cfg_we = 1'b0;
        ch_en[2] = 1'b1;
        cap_a = '0; cap_b = '0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            cap_a[k-1] = clk_div[2];
            cap_b[k-1] = cfg_pend[2];
            if (k == 4) cfg_write(2, 1, 1'b0);
            else cfg_we = 1'b0;
        end
        check("retune_clk_shape", cap_a, 16'h6600);
        check("retune_pend_shape", cap_b, 16'h01F0);

        // Staggered channels at TC 4 and TC 6, then sync_clr
        @(negedge clock);
        ch_en = '0;
        cfg_write(0, 4, 1'b0);
        @(negedge clock);
        cfg_write(1, 20, 1'b0);
        @(negedge clock);
        cfg_we = 1'b0;
        ch_en[0] = 1'b1;
        repeat (3) @(negedge clock);
        ch_en[1] = 1'b1;
        repeat (5) @(negedge clock);
        cfg_write(1, 6, 1'b0);
        @(negedge clock);
        cfg_we = 1'b0;
        check("sync_pre_pend", cfg_pend[1], 1'b1);
        @(negedge clock);
        sync_clr = 1'b1;
        cfg_write(0, 4, 1'b0);
        @(negedge clock);
        sync_clr = 1'b0;
        cfg_we = 1'b0;
        check("sync_clk_cleared", clk_div[1:0], 2'b00);
        check("sync_pend_state", cfg_pend, 3'b001);
        cap_a = '0; cap_b = '0; cap_c = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            cap_a[k-1] = clk_div[0];
            cap_b[k-1] = clk_div[1];
            cap_c[k-1] = cfg_pend[0];
        end
        check("sync_ch0_shape", cap_a, 16'h00F0);
        check("sync_ch1_shape", cap_b, 16'h00C0);
        check("sync_ch0_pend_shape", cap_c, 16'h000F);

        // Randomized run against the behavioural model
        @(negedge clock);
        ch_en = '0; cfg_we = 1'b0; sync_clr = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            for (int i = 0; i < N_CH; i++) begin
                exp_clk[i]  = m[i].clk;
                exp_tick[i] = m[i].tick;
                exp_pend[i] = m[i].pend;
            end
            check($sformatf("rand_c%0d", c), {clk_div, tick, cfg_pend},
                  {exp_clk, exp_tick, exp_pend});
            for (int i = 0; i < N_CH; i++) r_en[i] = ($urandom_range(0, 7) != 0);
            r_sync = ($urandom_range(0, 39) == 0);
            r_we   = ($urandom_range(0, 5) == 0);
            r_ch   = CH_W'($urandom_range(0, 3));
            r_tc   = $urandom_range(0, 6);
            r_mode = 1'($urandom_range(0, 1));
            ch_en = r_en; sync_clr = r_sync; cfg_we = r_we;
            cfg_ch = r_ch; cfg_tc = CNT_W'(r_tc); cfg_mode = r_mode;
            model_step(r_en, r_sync, r_we, r_ch, r_tc, r_mode);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_multi_clk_div
